// File: rtl/cpu_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared types for the bit-serial CPU execution sequencer:
//             opcode, ALU select and FSM state encodings plus opcode decodes.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDI = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_OUT = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_NONE   = 3'd0,
        ALU_PASS_B = 3'd1,
        ALU_ADD    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXEC   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Ops that stream WIDTH bits through the serial ALU.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= OP_LDI) && (op <= OP_XOR);
    endfunction

    // Opcodes 8..15 are undefined.
    function automatic logic is_legal_op(input logic [3:0] op);
        return ~op[3];
    endfunction

    // Serial ALU function for each opcode; SUB reuses the adder with
    // an inverted B stream and carry-in of 1.
    function automatic alu_sel_e alu_decode(input logic [3:0] op);
        case (op)
            OP_LDI:         return ALU_PASS_B;
            OP_ADD, OP_SUB: return ALU_ADD;
            OP_AND:         return ALU_AND;
            OP_OR:          return ALU_OR;
            OP_XOR:         return ALU_XOR;
            default:        return ALU_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_ctrl_if
//  Brief    : Loader handshake and datapath strobe bundle of the execution
//             sequencer. master = loader/datapath side, slave = sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int c_idx_w = $clog2(WIDTH);

    // loader -> sequencer
    logic               start;
    logic [3:0]         opcode;
    logic [11:0]        instr;

    // sequencer -> loader
    logic               busy;
    logic               done;
    logic               illegal;
    logic               start_drop;

    // sequencer -> datapath
    logic               op_load;
    logic [7:0]         imm;
    logic               carry_init;
    logic               carry_val;
    logic               b_invert;
    logic               shift_en;
    logic [c_idx_w-1:0] bit_idx;
    logic [2:0]         alu_sel;
    logic               out_we;

    modport master (
        output start, opcode, instr,
        input  busy, done, illegal, start_drop,
        input  op_load, imm, carry_init, carry_val, b_invert,
        input  shift_en, bit_idx, alu_sel, out_we
    );

    modport slave (
        input  start, opcode, instr,
        output busy, done, illegal, start_drop,
        output op_load, imm, carry_init, carry_val, b_invert,
        output shift_en, bit_idx, alu_sel, out_we
    );

endinterface
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_seq_ctrl
//  Brief    : Execution sequencer of the bit-serial CPU. Captures an
//             instruction, then strobes operand load, WIDTH serial shift
//             cycles and the final write/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cpu_seq_ctrl_if.slave   bus
);
    import cpu_pkg::*;

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [3:0]         r_opcode;
    logic [7:0]         r_imm;
    logic               w_capture;

    logic               w_busy;
    logic               w_done;
    logic               w_illegal;
    logic               w_op_load;
    logic               w_carry_init;
    logic               w_carry_val;
    logic               w_b_invert;
    logic               w_shift_en;
    logic [c_cnt_w-1:0] w_bit_idx;
    alu_sel_e           w_alu_sel;
    logic               w_out_we;

    // instr[11:8] is reserved and deliberately not used.
    logic               w_unused_rsvd;
    assign w_unused_rsvd = ^bus.instr[11:8];

    // State, bit counter and instruction capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_opcode <= 4'd0;
            r_imm    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_opcode <= bus.opcode;
                r_imm    <= bus.instr[7:0];
            end
        end
    end

    // Next-state logic and state-decoded datapath strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        w_op_load    = 1'b0;
        w_carry_init = 1'b0;
        w_carry_val  = 1'b0;
        w_b_invert   = 1'b0;
        w_shift_en   = 1'b0;
        w_bit_idx    = '0;
        w_out_we     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_op_load    = 1'b1;
                w_carry_init = 1'b1;
                w_carry_val  = (r_opcode == OP_SUB);
                w_cnt_nxt    = '0;
                w_state_nxt  = is_shift_op(r_opcode) ? ST_EXEC : ST_FINISH;
            end
            ST_EXEC: begin
                w_shift_en = 1'b1;
                w_bit_idx  = r_cnt;
                w_b_invert = (r_opcode == OP_SUB);
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_FINISH: begin
                w_done      = 1'b1;
                w_out_we    = (r_opcode == OP_OUT);
                w_illegal   = ~is_legal_op(r_opcode);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy    = (r_state != ST_IDLE);
    // ALU function is held for the whole operation, parked at NONE in IDLE.
    assign w_alu_sel = w_busy ? alu_decode(r_opcode) : ALU_NONE;

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.illegal    = w_illegal;
    // Only combinational path from start: flag a request that is ignored.
    assign bus.start_drop = bus.start & w_busy;
    assign bus.op_load    = w_op_load;
    assign bus.imm        = r_imm;
    assign bus.carry_init = w_carry_init;
    assign bus.carry_val  = w_carry_val;
    assign bus.b_invert   = w_b_invert;
    assign bus.shift_en   = w_shift_en;
    assign bus.bit_idx    = w_bit_idx;
    assign bus.alu_sel    = w_alu_sel;
    assign bus.out_we     = w_out_we;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_seq_ctrl
//  Brief    : Scoreboard bench for cpu_seq_ctrl. Stimulus pushes the
//             expected per-operation outcome; a monitor tallies strobes while
//             busy and compares against the queue head when done appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cpu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int op;
        int imm;
        int t0;
        int lat;
        int n_shift;
        int n_binv;
        int n_outwe;
        int ill;
        int alu;
        int cv;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   idle_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin : monitor
        int   ns, nb, nw, nl, ierr, aerr, lerr;
        exp_t e;
        ns = 0; nb = 0; nw = 0; nl = 0; ierr = 0; aerr = 0; lerr = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!bus.busy) begin
                if (bus.done | bus.shift_en | bus.out_we | bus.illegal |
                    bus.op_load | bus.carry_init | bus.carry_val | bus.b_invert)
                    idle_err++;
                if (bus.bit_idx != 0 || bus.alu_sel != 0)
                    idle_err++;
                ns = 0; nb = 0; nw = 0; nl = 0; ierr = 0; aerr = 0; lerr = 0;
            end else begin
                if (bus.op_load) begin
                    nl++;
                    if (!bus.carry_init || bus.shift_en ||
                        (q.size() > 0 && bus.carry_val != q[0].cv[0]))
                        lerr++;
                end else if (bus.carry_init || bus.carry_val) begin
                    lerr++;
                end
                if (bus.shift_en) begin
                    if (bus.bit_idx != ns) ierr++;
                    ns++;
                end else if (bus.bit_idx != 0) begin
                    ierr++;
                end
                if (bus.b_invert) begin
                    nb++;
                    if (!bus.shift_en) ierr++;
                end
                if (bus.out_we) begin
                    nw++;
                    if (!bus.done) ierr++;
                end
                if (bus.illegal && !bus.done) ierr++;
                if (q.size() > 0 && bus.alu_sel != q[0].alu) aerr++;
                if (bus.done) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("op%0d_done_cycle", e.op), cyc, e.t0 + e.lat);
                        check($sformatf("op%0d_shift_cnt", e.op), ns, e.n_shift);
                        check($sformatf("op%0d_binv_cnt", e.op), nb, e.n_binv);
                        check($sformatf("op%0d_outwe_cnt", e.op), nw, e.n_outwe);
                        check($sformatf("op%0d_illegal", e.op), bus.illegal, e.ill);
                        check($sformatf("op%0d_imm", e.op), bus.imm, e.imm);
                        check($sformatf("op%0d_load_cnt", e.op), nl, 1);
                        check($sformatf("op%0d_load_err", e.op), lerr, 0);
                        check($sformatf("op%0d_idx_err", e.op), ierr, 0);
                        check($sformatf("op%0d_alu_err", e.op), aerr, 0);
                    end
                end
            end
        end
    end

    // Drive one start cycle from a falling edge; checks start_drop mid-cycle.
    task automatic drive_start(input int op, input int ins, input int exp_drop);
        bus.start  = 1'b1;
        bus.opcode = op[3:0];
        bus.instr  = ins[11:0];
        #1;
        check($sformatf("start_drop_op%0d", op), bus.start_drop, exp_drop);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.opcode = 4'd0;
        bus.instr  = 12'd0;
    endtask

    task automatic issue(input int op, input int ins, input int lat, input int ns,
                         input int nb, input int nw, input int ill, input int alu,
                         input int cv);
        exp_t e;
        e.op = op; e.imm = ins & 8'hFF; e.t0 = cyc; e.lat = lat;
        e.n_shift = ns; e.n_binv = nb; e.n_outwe = nw; e.ill = ill;
        e.alu = alu; e.cv = cv;
        q.push_back(e);
        drive_start(op, ins, 0);
    endtask

    // Bounded wait for the scoreboard to drain, then step past FINISH.
    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (q.size() > 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, q.size(), 0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_strobes"},
              {bus.busy, bus.done, bus.illegal, bus.start_drop, bus.op_load,
               bus.carry_init, bus.carry_val, bus.b_invert, bus.shift_en, bus.out_we},
              10'd0);
        check({name, "_imm"}, bus.imm, 0);
        check({name, "_bit_idx"}, bus.bit_idx, 0);
        check({name, "_alu_sel"}, bus.alu_sel, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.start  = 1'b0;
        bus.opcode = 4'd0;
        bus.instr  = 12'd0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // start coincident with reset must be ignored
        bus.start  = 1'b1;
        bus.opcode = 4'd2;
        bus.instr  = 12'h0AB;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.opcode = 4'd0;
        bus.instr  = 12'd0;
        rst        = 1'b0;
        @(negedge clk);
        check("start_with_rst_busy", bus.busy, 0);
        check("start_with_rst_imm", bus.imm, 0);
        @(negedge clk);

        // ADD 0x35: done at T+10, busy low at T+11
        issue(2, 12'h035, 10, 8, 0, 0, 0, 2, 0);
        wait_drain("add");
        check("add_busy_low", bus.busy, 0);

        // SUB 0x01: carry 1, B inverted for all 8 shifts
        issue(3, 12'h001, 10, 8, 8, 0, 0, 2, 1);
        wait_drain("sub");

        // OUT then NOP started at FINISH+1
        issue(7, 12'h0AA, 2, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        issue(0, 12'h0C3, 2, 0, 0, 0, 0, 0, 0);
        wait_drain("out_nop");

        // Illegal opcode 12; reserved instr bits set
        issue(12, 12'hF5A, 2, 0, 0, 0, 1, 0, 0);
        wait_drain("illegal");

        // XOR with a dropped OR request during EXEC
        issue(6, 12'h00F, 10, 8, 0, 0, 0, 5, 0);
        repeat (2) @(negedge clk);
        drive_start(5, 12'h0F0, 1);
        wait_drain("xor_drop");

        // LDI reset at its 4th EXEC cycle: no done, everything cleared
        drive_start(1, 12'h077, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_idle", bus.busy, 0);

        // Fresh ADD after reset runs the full EXEC
        issue(2, 12'h0FF, 10, 8, 0, 0, 0, 2, 0);
        wait_drain("add_after_rst");

        check("idle_strobes", idle_err, 0);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
